// File: rtl/mips_step_ctrl.sv
// Run/step/halt sequencer that gates a MIPS core with one-cycle clock-enable pulses.
// Optional breakpoint halt is compiled in when BREAKPOINT_EN is defined.
module mips_step_ctrl #(
    parameter int PRESC_DIV = 50000000,
    parameter int CNT_W     = 26
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic        step_i,
    input  logic        halt_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] bp_addr_i,
    input  logic        bp_valid_i,
    output logic        cpu_en_o,
    output logic [1:0]  state_o,
    output logic [15:0] instr_cnt_o,
    output logic        bp_hit_o
);

    // state | meaning
    // IDLE  | out of reset, core gated, waiting for run or step
    // RUN   | free-run, one enable pulse every PRESC_DIV cycles
    // STEP  | single instruction, pulse issued on entry
    // HALT  | stopped by halt_i, end of step, or breakpoint
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PRESC_TC = CNT_W'(PRESC_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             cpu_en_q, cpu_en_d;
    logic [15:0]      instr_cnt_q, instr_cnt_d;
    logic             bp_hit_q, bp_hit_d;
    logic             first_q, first_d;
    logic             run_q, step_q;
    logic             run_rise, step_rise, tc, bp_match;

    assign run_rise  = run_i & ~run_q;
    assign step_rise = step_i & ~step_q;
    assign tc        = (presc_q == PRESC_TC);

`ifdef BREAKPOINT_EN
    // The first pulse after entering RUN always issues so a restart can leave a matching PC.
    assign bp_match = bp_valid_i && (pc_i == bp_addr_i) && !first_q;
`else
    logic unused_bp;
    assign unused_bp = ^{pc_i, bp_addr_i, bp_valid_i, first_q};
    assign bp_match  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        cpu_en_d = 1'b0;
        bp_hit_d = 1'b0;
        first_d  = first_q;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (halt_i)         state_d = ST_HALT;
                else if (run_rise)  state_d = ST_RUN;
                else if (step_rise) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (halt_i)              state_d = ST_HALT;
                else if (step_rise)      state_d = ST_STEP;
                else if (tc && bp_match) begin
                    state_d  = ST_HALT;
                    bp_hit_d = 1'b1;
                end
                else                     state_d = ST_RUN;
            end
            ST_STEP: begin
                if (halt_i)        state_d = ST_HALT;
                else if (run_rise) state_d = ST_RUN;
                else               state_d = ST_HALT;
            end
        endcase

        if (state_d == ST_STEP && state_q != ST_STEP)
            cpu_en_d = 1'b1;

        if (state_q == ST_RUN && state_d == ST_RUN) begin
            presc_d  = tc ? '0 : presc_q + CNT_W'(1);
            cpu_en_d = tc;
            if (tc)
                first_d = 1'b0;
        end

        if (state_d == ST_RUN && state_q != ST_RUN)
            first_d = 1'b1;

        if (state_q == ST_HALT && state_d == ST_HALT)
            bp_hit_d = bp_hit_q;
    end

    assign instr_cnt_d = instr_cnt_q + {15'd0, cpu_en_d};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            cpu_en_q    <= 1'b0;
            instr_cnt_q <= 16'd0;
            bp_hit_q    <= 1'b0;
            first_q     <= 1'b0;
            run_q       <= run_i;
            step_q      <= step_i;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cpu_en_q    <= cpu_en_d;
            instr_cnt_q <= instr_cnt_d;
            bp_hit_q    <= bp_hit_d;
            first_q     <= first_d;
            run_q       <= run_i;
            step_q      <= step_i;
        end
    end

    assign cpu_en_o    = cpu_en_q;
    assign state_o     = state_q;
    assign instr_cnt_o = instr_cnt_q;
`ifdef BREAKPOINT_EN
    assign bp_hit_o    = bp_hit_q;
`else
    logic unused_hit;
    assign unused_hit  = bp_hit_q;
    assign bp_hit_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Bench for mips_step_ctrl at PRESC_DIV=4: directed vector table, corner sequences,
// and randomized stimulus against an event-level reference model.
module tb_mips_step_ctrl;
    localparam int PRESC_DIV = 4;
    localparam int CNT_W     = 4;
`ifdef BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        run_i = 1'b0;
    logic        step_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic [31:0] bp_addr_i = 32'd0;
    logic        bp_valid_i = 1'b0;
    logic        cpu_en_o;
    logic [1:0]  state_o;
    logic [15:0] instr_cnt_o;
    logic        bp_hit_o;

    int checks = 0;
    int failures = 0;

    mips_step_ctrl #(.PRESC_DIV(PRESC_DIV), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .run_i(run_i), .step_i(step_i),
        .halt_i(halt_i), .pc_i(pc_i), .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i),
        .cpu_en_o(cpu_en_o), .state_o(state_o), .instr_cnt_o(instr_cnt_o),
        .bp_hit_o(bp_hit_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: counts clock edges spent in RUN since entry; pulses on multiples of PRESC_DIV.
    int m_state = 0;
    int m_runk  = 0;
    int m_cnt   = 0;
    bit m_en    = 0;
    bit m_bp    = 0;
    bit p_run   = 0;
    bit p_step  = 0;

    task automatic model_step();
        bit rr, sr, pulse, bpn;
        int ns;
        if (reset_i) begin
            m_state = 0; m_runk = 0; m_cnt = 0; m_en = 0; m_bp = 0;
        end else begin
            rr = run_i && !p_run;
            sr = step_i && !p_step;
            ns = m_state; pulse = 0; bpn = 0;
            case (m_state)
                0, 3: begin
                    if (halt_i) ns = 3;
                    else if (rr) ns = 1;
                    else if (sr) ns = 2;
                end
                1: begin
                    if (halt_i) ns = 3;
                    else if (sr) ns = 2;
                    else begin
                        m_runk++;
                        if (m_runk % PRESC_DIV == 0) begin
                            if (BP_EN && bp_valid_i && pc_i == bp_addr_i && m_runk != PRESC_DIV) begin
                                ns = 3; bpn = 1;
                            end else pulse = 1;
                        end
                    end
                end
                default: begin
                    if (halt_i) ns = 3;
                    else if (rr) ns = 1;
                    else ns = 3;
                end
            endcase
            if (ns == 2) pulse = 1;
            if (ns == 1 && m_state != 1) m_runk = 0;
            if (m_state == 3 && ns == 3) bpn = m_bp;
            m_state = ns;
            m_en = pulse;
            m_bp = bpn;
            m_cnt = (m_cnt + int'(pulse)) % 65536;
        end
        p_run = run_i;
        p_step = step_i;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " state"}, 32'(state_o), 32'(m_state));
        check({tag, " cpu_en"}, 32'(cpu_en_o), 32'(m_en));
        check({tag, " instr_cnt"}, 32'(instr_cnt_o), 32'(m_cnt));
        check({tag, " bp_hit"}, 32'(bp_hit_o), 32'(m_bp));
    endtask

    typedef struct {
        logic        rst, run, step, halt;
        logic [1:0]  st;
        logic        en;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic run, input logic step, input logic halt,
                       input logic [1:0] st, input logic en, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.run = run; v.step = step; v.halt = halt;
        v.st = st; v.en = en; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        // rst run step halt -> state en cnt
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 1, 1, 2);
        add(0, 1, 0, 0, 1, 0, 2);
        add(0, 1, 0, 0, 1, 0, 2);
        add(0, 1, 0, 0, 1, 0, 2);
        add(0, 1, 0, 0, 1, 1, 3);
        add(0, 1, 0, 1, 3, 0, 3);
        add(0, 0, 0, 0, 3, 0, 3);
        add(0, 0, 1, 0, 2, 1, 4);
        add(0, 0, 1, 0, 3, 0, 4);
        add(0, 0, 0, 0, 3, 0, 4);
        add(0, 0, 1, 0, 2, 1, 5);
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 3, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset_i = vecs[i].rst; run_i = vecs[i].run;
            step_i = vecs[i].step; halt_i = vecs[i].halt;
            tick();
            check($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("vec%0d cpu_en", i), 32'(cpu_en_o), 32'(vecs[i].en));
            check($sformatf("vec%0d instr_cnt", i), 32'(instr_cnt_o), 32'(vecs[i].cnt));
            check($sformatf("vec%0d bp_hit", i), 32'(bp_hit_o), 32'(0));
        end

        // halt and run rise together on the terminal-count cycle
        reset_i = 1; run_i = 0; step_i = 0; halt_i = 0; tick();
        reset_i = 0; run_i = 1; tick();
        run_i = 0; tick(); tick(); tick();
        check("tc_halt pre state", 32'(state_o), 32'd1);
        run_i = 1; halt_i = 1; tick();
        check("tc_halt state", 32'(state_o), 32'd3);
        check("tc_halt cpu_en", 32'(cpu_en_o), 32'd0);
        check("tc_halt instr_cnt", 32'(instr_cnt_o), 32'd0);

        // counter wrap: preload 0xFFFF through the counter's next-value net, then step once
        halt_i = 0; run_i = 0; step_i = 0;
        force dut.instr_cnt_d = 16'hFFFF;
        tick();
        release dut.instr_cnt_d;
        m_cnt = 65535;
        check("wrap preset", 32'(instr_cnt_o), 32'hFFFF);
        step_i = 1; tick();
        check("wrap state", 32'(state_o), 32'd2);
        check("wrap cpu_en", 32'(cpu_en_o), 32'd1);
        check("wrap instr_cnt", 32'(instr_cnt_o), 32'h0000);
        step_i = 0; tick();
        check("wrap after state", 32'(state_o), 32'd3);

        // breakpoint sequence
        reset_i = 1; run_i = 0; tick();
        reset_i = 0; bp_addr_i = 32'h0040_0008; bp_valid_i = 1; pc_i = 32'h0040_0008;
        run_i = 1; tick();
        check_model("bp entry");
        for (int i = 0; i < 8; i++) begin
            tick();
            check_model($sformatf("bp run%0d", i + 1));
        end
        if (BP_EN) begin
            check("bp state", 32'(state_o), 32'd3);
            check("bp hit", 32'(bp_hit_o), 32'd1);
            check("bp cnt", 32'(instr_cnt_o), 32'd1);
        end else begin
            check("nobp hit", 32'(bp_hit_o), 32'd0);
            check("nobp cnt", 32'(instr_cnt_o), 32'd2);
        end
        run_i = 0; tick(); check_model("bp drop");
        run_i = 1; tick(); check_model("bp rerun");
        for (int i = 0; i < 4; i++) begin
            tick();
            check_model($sformatf("bp rerun%0d", i + 1));
        end

        // randomized stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            reset_i = (c == 0) || ($urandom_range(63) == 0);
            if ($urandom_range(9) == 0) run_i = ~run_i;
            if ($urandom_range(9) == 0) step_i = ~step_i;
            halt_i = ($urandom_range(24) == 0);
            bp_valid_i = 1'($urandom_range(1));
            pc_i = ($urandom_range(1) == 1) ? bp_addr_i : $urandom;
            tick();
            check_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
